// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the fetch FSM state encoding and the instruction/PC step sizes.
package instr_fetch_ctrl_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_FULL  = 2'd2,
    FETCH_DRAIN = 2'd3
  } fetch_state_e;

  // A memory request is outstanding in both REQ and DRAIN.
  function automatic logic state_issues_req(input fetch_state_e s);
    return (s == FETCH_REQ) || (s == FETCH_DRAIN);
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_fetch_buffer.sv
// Small synchronous FIFO holding {pc, instr} pairs for the decode stage.
// Flush wins over push; a full buffer accepts a push when it pops in the same cycle.
module instr_fetch_ctrl_fetch_buffer #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 64,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_s;
  logic             empty_s;
  logic             do_pop_s;
  logic             do_push_s;

  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign empty_s   = (count_r == {CNT_W{1'b0}});
  assign do_pop_s  = pop & ~empty_s;
  assign do_push_s = push & (~full_s | do_pop_s);

  // Storage, pointers and occupancy; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= RST_VAL;
      end
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives the instruction memory req/ack port,
// buffers returned words with their PCs and handles redirects, including in-flight discard.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_IM_Req,
  output logic [XLEN-1:0] o_IM_Addr,
  input  logic            i_IM_Ack,
  input  logic [31:0]     i_IM_Data,
  output logic            o_Instr_Valid,
  output logic [31:0]     o_Instr,
  output logic [XLEN-1:0] o_PC,
  input  logic            i_Instr_Ready,
  input  logic            i_Redirect,
  input  logic [XLEN-1:0] i_Redirect_PC
);

  localparam int ENTRY_W = XLEN + INSTR_W;
  localparam int CNT_W   = $clog2(BUF_DEPTH+1);

  fetch_state_e     state_r;
  fetch_state_e     state_next_s;
  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  pc_next_s;
  logic [XLEN-1:0]  tgt_r;
  logic [XLEN-1:0]  tgt_next_s;
  logic             req_r;
  logic [XLEN-1:0]  redir_tgt_s;
  logic [XLEN-1:0]  pc_inc_s;
  logic             push_s;
  logic             pop_s;
  logic             flush_s;
  logic             fills_buf_s;
  logic [ENTRY_W-1:0] head_s;
  logic [CNT_W-1:0] buf_count_s;
  logic             buf_full_s;
  logic             buf_empty_s;

  assign redir_tgt_s = i_Redirect_PC & {{(XLEN-2){1'b1}}, 2'b00};
  assign pc_inc_s    = pc_r + XLEN'(PC_INC);
  assign pop_s       = ~buf_empty_s & i_Instr_Ready & ~i_Redirect;
  // Whether an accepted word leaves the buffer with no free slot.
  assign fills_buf_s = pop_s ? buf_full_s : (buf_count_s == CNT_W'(BUF_DEPTH-1));

  // Next-state, PC/target update and buffer control.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    tgt_next_s   = tgt_r;
    push_s       = 1'b0;
    flush_s      = 1'b0;
    case (state_r)
      FETCH_IDLE: begin
        if (i_Redirect) begin
          flush_s   = 1'b1;
          pc_next_s = redir_tgt_s;
        end else begin
          pc_next_s = pc_r;
        end
        state_next_s = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (i_Redirect) begin
          flush_s = 1'b1;
          if (i_IM_Ack) begin
            pc_next_s    = redir_tgt_s;
            state_next_s = FETCH_REQ;
          end else begin
            tgt_next_s   = redir_tgt_s;
            state_next_s = FETCH_DRAIN;
          end
        end else if (i_IM_Ack) begin
          push_s       = 1'b1;
          pc_next_s    = pc_inc_s;
          state_next_s = fills_buf_s ? FETCH_FULL : FETCH_REQ;
        end else begin
          state_next_s = FETCH_REQ;
        end
      end
      FETCH_FULL: begin
        if (i_Redirect) begin
          flush_s      = 1'b1;
          pc_next_s    = redir_tgt_s;
          state_next_s = FETCH_REQ;
        end else if (pop_s) begin
          state_next_s = FETCH_REQ;
        end else begin
          state_next_s = FETCH_FULL;
        end
      end
      FETCH_DRAIN: begin
        // The in-flight word is dropped; the newest target is the one that counts.
        if (i_Redirect) begin
          flush_s    = 1'b1;
          tgt_next_s = redir_tgt_s;
        end else begin
          tgt_next_s = tgt_r;
        end
        if (i_IM_Ack) begin
          pc_next_s    = i_Redirect ? redir_tgt_s : tgt_r;
          state_next_s = FETCH_REQ;
        end else begin
          state_next_s = FETCH_DRAIN;
        end
      end
      default: begin
        flush_s      = 1'b1;
        state_next_s = FETCH_IDLE;
      end
    endcase
  end

  // State, PC, pending target and registered request flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= FETCH_IDLE;
      pc_r    <= RESET_PC;
      tgt_r   <= RESET_PC;
      req_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
      tgt_r   <= tgt_next_s;
      req_r   <= state_issues_req(state_next_s);
    end
  end

  instr_fetch_ctrl_fetch_buffer #(
    .DEPTH   (BUF_DEPTH),
    .WIDTH   (ENTRY_W),
    .RST_VAL ({RESET_PC, {INSTR_W{1'b0}}})
  ) u_fetch_buffer (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .flush (flush_s),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({pc_r, i_IM_Data}),
    .rdata (head_s),
    .count (buf_count_s),
    .full  (buf_full_s),
    .empty (buf_empty_s)
  );

  assign o_IM_Req      = req_r;
  assign o_IM_Addr     = pc_r;
  assign o_Instr_Valid = ~buf_empty_s;
  assign o_PC          = head_s[ENTRY_W-1:INSTR_W];
  assign o_Instr       = head_s[INSTR_W-1:0];

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Fetch sequencer in front of the instruction memory port.
- Owns the fetch PC and issues word requests to the memory over a req/ack handshake.
- Buffers returned instructions with their PCs in a small FIFO for the decode stage.
- Handles pipeline redirects (branch/jump/trap), including discarding a request already in flight.

Parameters:
- XLEN, 32, address/PC width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, instruction buffer entries (power of two, >=2).

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- o_IM_Req  output  1  memory request.
- o_IM_Addr  output  XLEN  word-aligned fetch address.
- i_IM_Ack  input  1  memory accepts request; data valid this cycle.
- i_IM_Data  input  32  instruction word, valid when i_IM_Ack=1.
- o_Instr_Valid  output  1  buffer head valid.
- o_Instr  output  32  buffer head instruction.
- o_PC  output  XLEN  PC of buffer head.
- i_Instr_Ready  input  1  decode consumes head when o_Instr_Valid=1.
- i_Redirect  input  1  redirect fetch, flush buffer.
- i_Redirect_PC  input  XLEN  redirect target; bits [1:0] ignored (forced 0).

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst_n is asynchronous, active low.
- Reset values: state IDLE, pc_q=RESET_PC, buffer empty, o_IM_Req=0, o_IM_Addr=RESET_PC, o_Instr_Valid=0, o_Instr=0, o_PC=RESET_PC.
- FSM states: IDLE, REQ, FULL, DRAIN. All outputs come from registers or state; there is no combinational path from i_IM_Data to o_Instr.
- o_IM_Req=1 in REQ and DRAIN. o_IM_Addr=pc_q.
- Protocol: once o_IM_Req rises, o_IM_Req and o_IM_Addr hold stable until the cycle i_IM_Ack=1. Ack in the same cycle as req rise is legal, which gives zero-wait memory.
- IDLE -> REQ: first clock edge after reset release.
- REQ, ack, no redirect: write {pc_q, i_IM_Data} to the buffer; pc_q += 4 (wraps modulo 2^XLEN). Next state is REQ if count_next < BUF_DEPTH, else FULL. count_next = count + 1 - pop.
- REQ, no ack: hold.
- FULL -> REQ: on a pop.
- REQ without ack, with i_Redirect: flush the buffer, latch target into tgt_q, go to DRAIN. pc_q and o_IM_Addr stay unchanged.
- REQ with ack and i_Redirect in the same cycle: ack data is discarded, the buffer is flushed, pc_q = target, state stays REQ. The next request goes to the target on the next cycle.
- FULL or IDLE with i_Redirect: flush, pc_q = target, go to REQ.
- DRAIN: wait for ack, discard its data, then pc_q = tgt_q and go to REQ.
  - A further redirect in DRAIN overwrites tgt_q.
  - Redirect and ack in the same DRAIN cycle: the newest target is used.
- Pop: o_Instr_Valid & i_Instr_Ready & ~i_Redirect. Redirect has priority over pop and over push.
- Simultaneous push and pop: count is unchanged. A full buffer may push in the same cycle it pops only if state is REQ. FULL does not issue a request in the pop cycle.
- Latency: an instruction acked in cycle N appears on o_Instr_Valid in cycle N+1. Throughput is one instruction per cycle with a zero-wait memory and decode always ready.
- Valid ordering: o_Instr_Valid is 0 in the cycle after a redirect. The first post-redirect instruction appears no earlier than 2 cycles after the redirect.
- Reset mid-transaction: o_IM_Req drops immediately (asynchronous). The memory abandons the request.

Decomposition:
- arvi_defines.vh: XLEN, INSTRUCTION_SIZE, fetch FSM state encodings (FETCH_IDLE/REQ/FULL/DRAIN), instruction word width, PC increment constant.
- One sub-module: fetch_buffer. Synchronous FIFO of {pc, instr} with push, pop, flush, count, full, empty. Flush has priority over push.

Test Plan:
- Reset, RESET_PC=0x0, ack tied 1, ready tied 1 -> o_IM_Req=1 from cycle 1. Addresses 0x0, 0x4, 0x8... o_Instr_Valid from cycle 2. o_PC/o_Instr match memory, one per cycle.
- Ready held 0 -> after 2 acks, state FULL and o_IM_Req=0. Head stays PC 0x0. Raise ready -> pops 0x0 and request resumes at 0x8.
- Ack delayed 3 cycles per request -> o_IM_Addr stable across wait cycles. Each instruction appears one cycle after its ack.
- Redirect to 0x100 while a request to 0x8 is pending without ack -> DRAIN. Addr stays 0x8 until ack and that data is not presented. Next request is 0x100. Buffer is empty the cycle after redirect.
- Redirect to 0x203 coinciding with an ack, and a second redirect to 0x400 during DRAIN -> 0x203 fetches at 0x200. In DRAIN, the 0x400 target wins. No stale PC reaches o_PC.
- Assert i_rst_n=0 mid-wait with o_IM_Req=1 -> o_IM_Req and o_Instr_Valid are 0 immediately. After release, fetch restarts at RESET_PC.
